seq_divider: RTL and testbench

//  Parametrised multi-cycle radix-2 restoring divider. Supports signed or unsigned operation, selected per transaction.

---
 rtl/seq_divider.sv | 130 +++++++++++++
 tb/tb_seq_divider.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider with valid/ready on both sides.
// Signed or unsigned per transaction; flags divide-by-zero and signed MIN/-1.
//
//  state | meaning
//  ------+------------------------------------------------------------
//  IDLE  | waiting for operands, in_ready high
//  CALC  | one quotient bit per cycle, MSB first, cnt counts down
//  FIX   | sign correction of quotient/remainder, results registered
//  DONE  | result presented, held until out_ready
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_dividend,
    input  logic [WIDTH-1:0] in_divisor,
    input  logic             in_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_zero,
    output logic             out_overflow,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] a_q;          // dividend magnitude, becomes quotient as it shifts
    logic [WIDTH-1:0] b_q;          // divisor magnitude (|MIN| fits as unsigned)
    logic [WIDTH:0]   pr_q;         // partial remainder
    logic [CW-1:0]    cnt_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic             accept;
    logic             in_zero;
    logic             in_ovf;
    logic [WIDTH-1:0] abs_dvd;
    logic [WIDTH-1:0] abs_dvs;
    logic [WIDTH+1:0] pr_sh;
    logic             pr_ge;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid && in_ready;

    assign in_zero = (in_divisor == '0);
    assign in_ovf  = in_signed && (in_dividend == MIN_VAL) && (in_divisor == '1);

    // Negation in WIDTH bits yields the exact unsigned magnitude, including |MIN|.
    assign abs_dvd = (in_signed && in_dividend[WIDTH-1]) ? -in_dividend : in_dividend;
    assign abs_dvs = (in_signed && in_divisor[WIDTH-1])  ? -in_divisor  : in_divisor;

    assign pr_sh = {pr_q, a_q[WIDTH-1]};
    assign pr_ge = (pr_sh >= {2'b00, b_q});

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (in_valid) state_nxt = (in_zero || in_ovf) ? DONE : CALC;
            CALC: if (cnt_q == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration datapath: operand capture and shift/subtract steps
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_q       <= '0;
            b_q       <= '0;
            pr_q      <= '0;
            cnt_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            a_q       <= abs_dvd;
            b_q       <= abs_dvs;
            pr_q      <= '0;
            cnt_q     <= CW'(WIDTH);
            neg_quo_q <= in_signed && (in_dividend[WIDTH-1] ^ in_divisor[WIDTH-1]);
            neg_rem_q <= in_signed && in_dividend[WIDTH-1];
        end else if (state == CALC) begin
            a_q   <= {a_q[WIDTH-2:0], pr_ge};
            pr_q  <= pr_ge ? (WIDTH+1)'(pr_sh - {2'b00, b_q}) : (WIDTH+1)'(pr_sh);
            cnt_q <= cnt_q - CW'(1);
        end
    end

    // Result registers: special cases load on accept, normal path loads in FIX
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_quotient  <= '0;
            out_remainder <= '0;
            out_div_zero  <= 1'b0;
            out_overflow  <= 1'b0;
        end else if (accept) begin
            out_div_zero <= in_zero;
            out_overflow <= in_ovf && !in_zero;
            if (in_zero) begin
                out_quotient  <= '1;
                out_remainder <= in_dividend;
            end else if (in_ovf) begin
                out_quotient  <= MIN_VAL;
                out_remainder <= '0;
            end
        end else if (state == FIX) begin
            out_quotient  <= neg_quo_q ? -a_q : a_q;
            out_remainder <= neg_rem_q ? -pr_q[WIDTH-1:0] : pr_q[WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: vector table plus back-pressure and
// mid-calculation reset sequences.
module tb_seq_divider;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         resetn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_dividend = '0;
    logic [W-1:0] in_divisor = '0;
    logic         in_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_quotient;
    logic [W-1:0] out_remainder;
    logic         out_div_zero;
    logic         out_overflow;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dividend(in_dividend), .in_divisor(in_divisor), .in_signed(in_signed),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_quotient(out_quotient), .out_remainder(out_remainder),
        .out_div_zero(out_div_zero), .out_overflow(out_overflow),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] dvd;
        logic [W-1:0] dvs;
        logic         sgn;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        logic         ov;
        int           lat;   // edges after the accepting edge until out_valid is seen
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Presents operands, waits for the result with out_ready low, checks it, then completes the handshake.
    task automatic run_op(input vec_t v, input string tag);
        int lat;
        @(negedge clk);
        chk({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
        in_dividend = v.dvd;
        in_divisor  = v.dvs;
        in_signed   = v.sgn;
        in_valid    = 1'b1;
        out_ready   = 1'b0;
        @(posedge clk);
        #1 in_valid = 1'b0;
        in_dividend = 16'hDEAD;
        in_divisor  = 16'hBEEF;
        in_signed   = ~v.sgn;
        @(negedge clk);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk({tag, " latency"}, 32'(lat), 32'(v.lat));
        chk({tag, " quotient"}, 32'(out_quotient), 32'(v.q));
        chk({tag, " remainder"}, 32'(out_remainder), 32'(v.r));
        chk({tag, " div_zero"}, 32'(out_div_zero), 32'(v.dz));
        chk({tag, " overflow"}, 32'(out_overflow), 32'(v.ov));
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, " idle after handshake"}, 32'({in_ready, out_valid, busy}), 32'b100);
    endtask

    initial begin
        vec_t v;

        vecs[0]  = '{16'd100,  16'd7,    1'b0, 16'd14,   16'd2,    1'b0, 1'b0, 17};
        vecs[1]  = '{16'hFFF9, 16'h0002, 1'b1, 16'hFFFD, 16'hFFFF, 1'b0, 1'b0, 17};
        vecs[2]  = '{16'h0007, 16'hFFFE, 1'b1, 16'hFFFD, 16'h0001, 1'b0, 1'b0, 17};
        vecs[3]  = '{16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 0};
        vecs[4]  = '{16'h1234, 16'h0000, 1'b1, 16'hFFFF, 16'h1234, 1'b1, 1'b0, 0};
        vecs[5]  = '{16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b1, 0};
        vecs[6]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, 1'b0, 17};
        vecs[7]  = '{16'h8000, 16'h0001, 1'b1, 16'h8000, 16'h0000, 1'b0, 1'b0, 17};
        vecs[8]  = '{16'hFF9C, 16'h0007, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, 1'b0, 17};
        vecs[9]  = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0001, 16'h0000, 1'b0, 1'b0, 17};
        vecs[10] = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, 17};
        vecs[11] = '{16'h0005, 16'h0009, 1'b0, 16'h0000, 16'h0005, 1'b0, 1'b0, 17};
        vecs[12] = '{16'hFFF9, 16'hFFFE, 1'b1, 16'h0003, 16'hFFFF, 1'b0, 1'b0, 17};

        // Reset state
        #12;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset quotient", 32'(out_quotient), 32'd0);
        chk("reset remainder", 32'(out_remainder), 32'd0);
        chk("reset flags", 32'({out_div_zero, out_overflow}), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("in_ready after reset", 32'(in_ready), 32'd1);

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        // Back-pressure: result held while new operands are offered
        @(negedge clk);
        in_dividend = 16'd100;
        in_divisor  = 16'd7;
        in_signed   = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 17; k++) @(posedge clk);
        @(negedge clk);
        chk("bp out_valid arrives", 32'(out_valid), 32'd1);
        in_dividend = 16'h0050;
        in_divisor  = 16'h0005;
        in_valid    = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp hold%0d", k),
                32'({out_valid, in_ready, busy, out_div_zero, out_overflow}), 32'b10100);
            chk($sformatf("bp q/r%0d", k), {out_quotient, out_remainder}, {16'd14, 16'd2});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("bp idle after release", 32'({in_ready, out_valid}), 32'b10);
        v = '{16'h0050, 16'h0005, 1'b0, 16'h0010, 16'h0000, 1'b0, 1'b0, 17};
        run_op(v, "bp next op");

        // Reset during the 5th CALC cycle abandons the division
        @(negedge clk);
        in_dividend = 16'd100;
        in_divisor  = 16'd7;
        in_signed   = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        for (int k = 0; k < 4; k++) @(posedge clk);
        #2;
        chk("midcalc busy before reset", 32'(busy), 32'd1);
        resetn = 1'b0;
        #1;
        chk("midcalc reset out_valid", 32'(out_valid), 32'd0);
        chk("midcalc reset busy", 32'(busy), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("midcalc in_ready after release", 32'(in_ready), 32'd1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                chk("midcalc no stale result", 32'(out_valid), 32'd0);
                break;
            end
        end
        v = '{16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 17};
        run_op(v, "post reset");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
